remote_load_return: RTL and testbench

- Receive-side counterpart of the tile's remote-request path.
- Accepts returned remote-load responses from the network RX endpoint and buffers them in a small FIFO.
- Performs byte/half-word extraction and sign/zero extension using the returned load_info, then routes each response to the integer regfile, the FP regfile or the icache fill port.
- Tracks outstanding remote loads issued by the load/store path and raises a full flag that stalls further issue.

---
 rtl/remote_load_return_pkg.sv | 37 +++
 rtl/remote_load_return_load_data_extract.sv | 41 ++++
 rtl/remote_load_return.sv | 151 +++++++++++++++
 tb/tb_remote_load_return.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_load_return_pkg.sv
// Shared types for the remote-load return path: load_info layout, FIFO payload, routing helper.
package remote_load_return_pkg;

  localparam int data_width_lp     = 32;
  localparam int reg_addr_width_lp = 5;

  typedef struct packed {
    logic       float_wb;
    logic       icache_fetch;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  localparam int load_info_width_lp = $bits(load_info_s);

  typedef struct packed {
    logic [data_width_lp-1:0]     data;
    logic [reg_addr_width_lp-1:0] reg_id;
    load_info_s                   load_info;
  } returned_pkt_s;

  typedef enum logic [1:0] {
    dest_int    = 2'd0,
    dest_float  = 2'd1,
    dest_icache = 2'd2
  } dest_e;

  // icache fetches take priority over the FP flag; anything else is an integer load
  function automatic dest_e route_dest(input load_info_s info);
    if (info.icache_fetch) return dest_icache;
    else if (info.float_wb) return dest_float;
    else return dest_int;
  endfunction

endpackage

// File: rtl/remote_load_return_load_data_extract.sv
// Byte/half-word extraction with sign or zero extension for returned load data.
module load_data_extract
  import remote_load_return_pkg::*;
(
  input  logic [data_width_lp-1:0]      data_i,
  input  logic [load_info_width_lp-1:0] load_info_i,
  output logic [data_width_lp-1:0]      data_o
);

  load_info_s info;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;
  logic        unused_route_bits;

  assign info              = load_info_s'(load_info_i);
  assign sext              = ~info.is_unsigned_op;
  assign unused_route_bits = info.float_wb ^ info.icache_fetch;

  always_comb begin
    byte_sel = data_i[7:0];
    case (info.part_sel)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
  end

  // half-words are always aligned, so only the upper select bit matters
  assign half_sel = info.part_sel[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    data_o = data_i;
    if (info.is_byte_op)
      data_o = {{24{sext & byte_sel[7]}}, byte_sel};
    else if (info.is_hex_op)
      data_o = {{16{sext & half_sel[15]}}, half_sel};
  end

endmodule

// File: rtl/remote_load_return.sv
// Remote-load return path: response FIFO, per-destination routing, outstanding credit tracking.
// Optional per-destination profiling counters when REMOTE_LOAD_RETURN_PROFILE_EN is defined.
module remote_load_return
  import remote_load_return_pkg::*;
#(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int els_p            = 2,
  parameter int max_out_p        = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               returned_v_i,
  input  logic [data_width_p-1:0]            returned_data_i,
  input  logic [reg_addr_width_p-1:0]        returned_reg_id_i,
  input  logic [load_info_width_lp-1:0]      returned_load_info_i,
  output logic                               returned_yumi_o,
  input  logic                               issue_v_i,
  output logic                               outstanding_full_o,
  output logic [$clog2(max_out_p+1)-1:0]     outstanding_count_o,
  output logic                               int_wb_v_o,
  output logic [reg_addr_width_p-1:0]        int_wb_rd_o,
  output logic [data_width_p-1:0]            int_wb_data_o,
  input  logic                               int_wb_yumi_i,
  output logic                               float_wb_v_o,
  output logic [reg_addr_width_p-1:0]        float_wb_rd_o,
  output logic [data_width_p-1:0]            float_wb_data_o,
  input  logic                               float_wb_yumi_i,
  output logic                               icache_v_o,
  output logic [data_width_p-1:0]            icache_data_o,
  input  logic                               icache_yumi_i
`ifdef REMOTE_LOAD_RETURN_PROFILE_EN
  ,
  output logic [31:0]                        prof_int_cnt_o,
  output logic [31:0]                        prof_float_cnt_o,
  output logic [31:0]                        prof_icache_cnt_o,
  output logic [31:0]                        prof_stall_cycles_o
`endif
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam int oc_w_lp  = $clog2(max_out_p + 1);

  returned_pkt_s             mem_r [els_p];
  returned_pkt_s             wr_pkt;
  returned_pkt_s             head;
  logic [ptr_w_lp-1:0]       wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]       fifo_cnt_r;
  logic                      fifo_full, fifo_v;
  logic                      alive_r;
  logic                      enq, deq;
  dest_e                     dest;
  logic [data_width_lp-1:0]  ext_data;
  logic [oc_w_lp-1:0]        out_cnt_r;

  assign fifo_full = (fifo_cnt_r == cnt_w_lp'(els_p));
  assign fifo_v    = (fifo_cnt_r != '0);
  assign head      = mem_r[rd_ptr_r];
  assign dest      = route_dest(head.load_info);

  // alive_r keeps the handshake quiet while reset is held
  assign returned_yumi_o = returned_v_i & ~fifo_full & alive_r;
  assign enq             = returned_yumi_o;

  assign wr_pkt.data      = returned_data_i;
  assign wr_pkt.reg_id    = returned_reg_id_i;
  assign wr_pkt.load_info = load_info_s'(returned_load_info_i);

  assign icache_v_o   = fifo_v & (dest == dest_icache);
  assign float_wb_v_o = fifo_v & (dest == dest_float);
  assign int_wb_v_o   = fifo_v & (dest == dest_int);

  assign deq = (icache_v_o & icache_yumi_i)
             | (float_wb_v_o & float_wb_yumi_i)
             | (int_wb_v_o & int_wb_yumi_i);

  load_data_extract u_extract (
    .data_i      (head.data),
    .load_info_i (head.load_info),
    .data_o      (ext_data)
  );

  assign int_wb_rd_o     = int_wb_v_o   ? head.reg_id : '0;
  assign int_wb_data_o   = int_wb_v_o   ? ext_data    : '0;
  assign float_wb_rd_o   = float_wb_v_o ? head.reg_id : '0;
  assign float_wb_data_o = float_wb_v_o ? head.data   : '0;
  assign icache_data_o   = icache_v_o   ? head.data   : '0;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= wr_pkt;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      alive_r    <= 1'b0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      alive_r <= 1'b1;
      if (enq) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      if (enq && !deq)      fifo_cnt_r <= fifo_cnt_r + cnt_w_lp'(1);
      else if (deq && !enq) fifo_cnt_r <= fifo_cnt_r - cnt_w_lp'(1);
    end
  end

  assign outstanding_count_o = out_cnt_r;
  assign outstanding_full_o  = (out_cnt_r == oc_w_lp'(max_out_p));

  // issue and return in the same cycle cancel out, even at the credit limit
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_cnt_r <= '0;
    end else if (issue_v_i && !deq) begin
      if (!outstanding_full_o) out_cnt_r <= out_cnt_r + oc_w_lp'(1);
    end else if (deq && !issue_v_i) begin
      if (out_cnt_r != '0) out_cnt_r <= out_cnt_r - oc_w_lp'(1);
    end
  end

`ifdef REMOTE_LOAD_RETURN_PROFILE_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prof_int_cnt_o      <= '0;
      prof_float_cnt_o    <= '0;
      prof_icache_cnt_o   <= '0;
      prof_stall_cycles_o <= '0;
    end else begin
      if (int_wb_v_o && int_wb_yumi_i)     prof_int_cnt_o    <= prof_int_cnt_o + 32'd1;
      if (float_wb_v_o && float_wb_yumi_i) prof_float_cnt_o  <= prof_float_cnt_o + 32'd1;
      if (icache_v_o && icache_yumi_i)     prof_icache_cnt_o <= prof_icache_cnt_o + 32'd1;
      if (fifo_v && !deq)                  prof_stall_cycles_o <= prof_stall_cycles_o + 32'd1;
    end
  end
`endif

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(issue_v_i && outstanding_full_o && !deq))
        else $error("remote load issued with no outstanding credit left");
      assert (!(deq && !issue_v_i && out_cnt_r == '0))
        else $error("unsolicited remote load response dequeued");
      assert (!(fifo_v && ((icache_yumi_i && !icache_v_o) || (float_wb_yumi_i && !float_wb_v_o)
                           || (int_wb_yumi_i && !int_wb_v_o))))
        else $error("yumi asserted on a port not selected by the head response");
    end
  end

endmodule

// File: tb/tb_remote_load_return.sv
// Directed bench for remote_load_return: extraction, routing, credits, async reset, optional profiling.
module tb_remote_load_return;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        returned_v_i = 1'b0;
  logic [31:0] returned_data_i = '0;
  logic [4:0]  returned_reg_id_i = '0;
  logic [6:0]  returned_load_info_i = '0;
  logic        returned_yumi_o;
  logic        issue_v_i = 1'b0;
  logic        outstanding_full_o;
  logic [4:0]  outstanding_count_o;
  logic        int_wb_v_o;
  logic [4:0]  int_wb_rd_o;
  logic [31:0] int_wb_data_o;
  logic        int_wb_yumi_i = 1'b0;
  logic        float_wb_v_o;
  logic [4:0]  float_wb_rd_o;
  logic [31:0] float_wb_data_o;
  logic        float_wb_yumi_i = 1'b0;
  logic        icache_v_o;
  logic [31:0] icache_data_o;
  logic        icache_yumi_i = 1'b0;
`ifdef REMOTE_LOAD_RETURN_PROFILE_EN
  logic [31:0] prof_int_cnt_o, prof_float_cnt_o, prof_icache_cnt_o, prof_stall_cycles_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  remote_load_return dut (
    .clk_i                (clk_i),
    .reset_n_i            (reset_n_i),
    .returned_v_i         (returned_v_i),
    .returned_data_i      (returned_data_i),
    .returned_reg_id_i    (returned_reg_id_i),
    .returned_load_info_i (returned_load_info_i),
    .returned_yumi_o      (returned_yumi_o),
    .issue_v_i            (issue_v_i),
    .outstanding_full_o   (outstanding_full_o),
    .outstanding_count_o  (outstanding_count_o),
    .int_wb_v_o           (int_wb_v_o),
    .int_wb_rd_o          (int_wb_rd_o),
    .int_wb_data_o        (int_wb_data_o),
    .int_wb_yumi_i        (int_wb_yumi_i),
    .float_wb_v_o         (float_wb_v_o),
    .float_wb_rd_o        (float_wb_rd_o),
    .float_wb_data_o      (float_wb_data_o),
    .float_wb_yumi_i      (float_wb_yumi_i),
    .icache_v_o           (icache_v_o),
    .icache_data_o        (icache_data_o),
    .icache_yumi_i        (icache_yumi_i)
`ifdef REMOTE_LOAD_RETURN_PROFILE_EN
    ,
    .prof_int_cnt_o       (prof_int_cnt_o),
    .prof_float_cnt_o     (prof_float_cnt_o),
    .prof_icache_cnt_o    (prof_icache_cnt_o),
    .prof_stall_cycles_o  (prof_stall_cycles_o)
`endif
  );

  // {float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel}
  function automatic logic [6:0] li(bit f, bit ic, bit u, bit b, bit h, logic [1:0] ps);
    return {f, ic, u, b, h, ps};
  endfunction

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      issue_v_i = 1'b1;
    end
    @(negedge clk_i);
    issue_v_i = 1'b0;
  endtask

  task automatic test_reset();
    returned_v_i = 1'b1;
    #3;
    checks++; if (returned_yumi_o !== 1'b0) begin errors++; $display("FAIL rst_yumi got %b want 0", returned_yumi_o); end
    checks++; if ({int_wb_v_o, float_wb_v_o, icache_v_o} !== 3'b000) begin errors++; $display("FAIL rst_valids got %b want 000", {int_wb_v_o, float_wb_v_o, icache_v_o}); end
    checks++; if (outstanding_full_o !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", outstanding_full_o); end
    checks++; if (outstanding_count_o !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", outstanding_count_o); end
    checks++; if ({int_wb_data_o, float_wb_data_o, icache_data_o} !== 96'd0) begin errors++; $display("FAIL rst_data got nonzero data outputs"); end
    checks++; if ({int_wb_rd_o, float_wb_rd_o} !== 10'd0) begin errors++; $display("FAIL rst_rd got %h want 0", {int_wb_rd_o, float_wb_rd_o}); end
    @(negedge clk_i);
    returned_v_i = 1'b0;
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if ({int_wb_v_o, float_wb_v_o, icache_v_o} !== 3'b000) begin errors++; $display("FAIL post_rst_valids got %b want 000", {int_wb_v_o, float_wb_v_o, icache_v_o}); end
  endtask

  task automatic test_byte_signed();
    issue_n(1);
    #1;
    checks++; if (outstanding_count_o !== 5'd1) begin errors++; $display("FAIL byte_count_up got %0d want 1", outstanding_count_o); end
    @(negedge clk_i);
    returned_v_i = 1'b1; returned_data_i = 32'h80FF7F01; returned_reg_id_i = 5'd5;
    returned_load_info_i = li(0, 0, 0, 1, 0, 2'd3);
    #1;
    checks++; if (returned_yumi_o !== 1'b1) begin errors++; $display("FAIL byte_yumi got %b want 1", returned_yumi_o); end
    @(negedge clk_i);
    returned_v_i = 1'b0; int_wb_yumi_i = 1'b1;
    #1;
    checks++; if (int_wb_v_o !== 1'b1) begin errors++; $display("FAIL byte_int_v got %b want 1", int_wb_v_o); end
    checks++; if (int_wb_rd_o !== 5'd5) begin errors++; $display("FAIL byte_rd got %0d want 5", int_wb_rd_o); end
    checks++; if (int_wb_data_o !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_data got %h want ffffff80", int_wb_data_o); end
    checks++; if ({float_wb_v_o, icache_v_o} !== 2'b00) begin errors++; $display("FAIL byte_other_v got %b want 00", {float_wb_v_o, icache_v_o}); end
    @(negedge clk_i);
    int_wb_yumi_i = 1'b0;
    #1;
    checks++; if (int_wb_v_o !== 1'b0) begin errors++; $display("FAIL byte_drained got %b want 0", int_wb_v_o); end
    checks++; if (outstanding_count_o !== 5'd0) begin errors++; $display("FAIL byte_count_down got %0d want 0", outstanding_count_o); end
  endtask

  task automatic test_half();
    logic [6:0]  it [4];
    logic [4:0]  rt [4];
    logic [31:0] et [4];
    it[0] = li(0, 0, 1, 0, 1, 2'd2); rt[0] = 5'd7;  et[0] = 32'h00008001;
    it[1] = li(0, 0, 1, 0, 1, 2'd0); rt[1] = 5'd8;  et[1] = 32'h0000ABCD;
    it[2] = li(0, 0, 0, 0, 1, 2'd3); rt[2] = 5'd9;  et[2] = 32'hFFFF8001;
    it[3] = li(0, 0, 1, 1, 0, 2'd1); rt[3] = 5'd10; et[3] = 32'h000000AB;
    issue_n(4);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk_i);
      returned_v_i = 1'b1; returned_data_i = 32'h8001ABCD;
      returned_load_info_i = it[2*p]; returned_reg_id_i = rt[2*p];
      @(negedge clk_i);
      returned_load_info_i = it[2*p+1]; returned_reg_id_i = rt[2*p+1];
      #1;
      checks++; if (returned_yumi_o !== 1'b1) begin errors++; $display("FAIL half_yumi[%0d] got %b want 1", p, returned_yumi_o); end
      @(negedge clk_i);
      returned_v_i = 1'b0; int_wb_yumi_i = 1'b1;
      #1;
      checks++; if ({int_wb_v_o, int_wb_rd_o, int_wb_data_o} !== {1'b1, rt[2*p], et[2*p]})
        begin errors++; $display("FAIL half_first[%0d] got v=%b rd=%0d data=%h want rd=%0d data=%h", p, int_wb_v_o, int_wb_rd_o, int_wb_data_o, rt[2*p], et[2*p]); end
      @(negedge clk_i);
      #1;
      checks++; if ({int_wb_v_o, int_wb_rd_o, int_wb_data_o} !== {1'b1, rt[2*p+1], et[2*p+1]})
        begin errors++; $display("FAIL half_second[%0d] got v=%b rd=%0d data=%h want rd=%0d data=%h", p, int_wb_v_o, int_wb_rd_o, int_wb_data_o, rt[2*p+1], et[2*p+1]); end
      @(negedge clk_i);
      int_wb_yumi_i = 1'b0;
    end
    #1;
    checks++; if (outstanding_count_o !== 5'd0) begin errors++; $display("FAIL half_count got %0d want 0", outstanding_count_o); end
  endtask

  task automatic test_routing();
    issue_n(3);
    @(negedge clk_i);
    returned_v_i = 1'b1; returned_data_i = 32'h00A00093; returned_reg_id_i = 5'd1;
    returned_load_info_i = li(1, 1, 0, 1, 0, 2'd0);
    #1;
    checks++; if (returned_yumi_o !== 1'b1) begin errors++; $display("FAIL route_yumi0 got %b want 1", returned_yumi_o); end
    @(negedge clk_i);
    returned_data_i = 32'hBF800000; returned_reg_id_i = 5'd2;
    returned_load_info_i = li(1, 0, 0, 1, 0, 2'd1);
    #1;
    checks++; if (returned_yumi_o !== 1'b1) begin errors++; $display("FAIL route_yumi1 got %b want 1", returned_yumi_o); end
    checks++; if (icache_v_o !== 1'b1) begin errors++; $display("FAIL route_icache_early got %b want 1", icache_v_o); end
    @(negedge clk_i);
    returned_data_i = 32'h87654321; returned_reg_id_i = 5'd3;
    returned_load_info_i = li(0, 0, 0, 0, 0, 2'd0);
    #1;
    checks++; if (returned_yumi_o !== 1'b0) begin errors++; $display("FAIL route_full_yumi got %b want 0", returned_yumi_o); end
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (returned_yumi_o !== 1'b0) begin errors++; $display("FAIL route_hold_yumi got %b want 0", returned_yumi_o); end
    @(negedge clk_i);
    icache_yumi_i = 1'b1;
    #1;
    checks++; if ({icache_v_o, float_wb_v_o, int_wb_v_o} !== 3'b100) begin errors++; $display("FAIL route_sel_icache got %b want 100", {icache_v_o, float_wb_v_o, int_wb_v_o}); end
    checks++; if (icache_data_o !== 32'h00A00093) begin errors++; $display("FAIL route_icache_data got %h want 00a00093", icache_data_o); end
    checks++; if (returned_yumi_o !== 1'b0) begin errors++; $display("FAIL route_no_bypass got %b want 0", returned_yumi_o); end
    @(negedge clk_i);
    icache_yumi_i = 1'b0;
    #1;
    checks++; if ({icache_v_o, float_wb_v_o, int_wb_v_o} !== 3'b010) begin errors++; $display("FAIL route_sel_float got %b want 010", {icache_v_o, float_wb_v_o, int_wb_v_o}); end
    checks++; if ({float_wb_rd_o, float_wb_data_o} !== {5'd2, 32'hBF800000}) begin errors++; $display("FAIL route_float got rd=%0d data=%h want rd=2 data=bf800000", float_wb_rd_o, float_wb_data_o); end
    checks++; if (returned_yumi_o !== 1'b1) begin errors++; $display("FAIL route_reopen got %b want 1", returned_yumi_o); end
    float_wb_yumi_i = 1'b1;
    @(negedge clk_i);
    returned_v_i = 1'b0; float_wb_yumi_i = 1'b0;
    #1;
    checks++; if ({icache_v_o, float_wb_v_o, int_wb_v_o} !== 3'b001) begin errors++; $display("FAIL route_sel_int got %b want 001", {icache_v_o, float_wb_v_o, int_wb_v_o}); end
    checks++; if ({int_wb_rd_o, int_wb_data_o} !== {5'd3, 32'h87654321}) begin errors++; $display("FAIL route_int got rd=%0d data=%h want rd=3 data=87654321", int_wb_rd_o, int_wb_data_o); end
    int_wb_yumi_i = 1'b1;
    @(negedge clk_i);
    int_wb_yumi_i = 1'b0;
    #1;
    checks++; if ({icache_v_o, float_wb_v_o, int_wb_v_o} !== 3'b000) begin errors++; $display("FAIL route_empty got %b want 000", {icache_v_o, float_wb_v_o, int_wb_v_o}); end
    checks++; if (outstanding_count_o !== 5'd0) begin errors++; $display("FAIL route_count got %0d want 0", outstanding_count_o); end
  endtask

  task automatic test_credits();
    issue_n(16);
    #1;
    checks++; if ({outstanding_full_o, outstanding_count_o} !== {1'b1, 5'd16}) begin errors++; $display("FAIL cred_full got full=%b count=%0d want 1/16", outstanding_full_o, outstanding_count_o); end
    @(negedge clk_i);
    returned_v_i = 1'b1; returned_data_i = 32'h11111111; returned_reg_id_i = 5'd4;
    returned_load_info_i = li(0, 0, 0, 0, 0, 2'd0);
    @(negedge clk_i);
    returned_data_i = 32'h22222222;
    @(negedge clk_i);
    returned_v_i = 1'b0; issue_v_i = 1'b1; int_wb_yumi_i = 1'b1;
    @(negedge clk_i);
    issue_v_i = 1'b0; int_wb_yumi_i = 1'b0;
    #1;
    checks++; if ({outstanding_full_o, outstanding_count_o} !== {1'b1, 5'd16}) begin errors++; $display("FAIL cred_same_cycle got full=%b count=%0d want 1/16", outstanding_full_o, outstanding_count_o); end
    checks++; if ({int_wb_v_o, int_wb_data_o} !== {1'b1, 32'h22222222}) begin errors++; $display("FAIL cred_head got v=%b data=%h want 1/22222222", int_wb_v_o, int_wb_data_o); end
    int_wb_yumi_i = 1'b1;
    @(negedge clk_i);
    int_wb_yumi_i = 1'b0;
    #1;
    checks++; if ({outstanding_full_o, outstanding_count_o} !== {1'b0, 5'd15}) begin errors++; $display("FAIL cred_release got full=%b count=%0d want 0/15", outstanding_full_o, outstanding_count_o); end
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    issue_n(7);
    @(negedge clk_i);
    returned_v_i = 1'b1; returned_data_i = 32'h33333333; returned_reg_id_i = 5'd6;
    returned_load_info_i = li(0, 0, 0, 0, 0, 2'd0);
    @(negedge clk_i);
    returned_data_i = 32'h44444444;
    @(negedge clk_i);
    returned_v_i = 1'b0;
    #1;
    checks++; if ({int_wb_v_o, outstanding_count_o} !== {1'b1, 5'd7}) begin errors++; $display("FAIL arst_setup got v=%b count=%0d want 1/7", int_wb_v_o, outstanding_count_o); end
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++; if ({int_wb_v_o, float_wb_v_o, icache_v_o} !== 3'b000) begin errors++; $display("FAIL arst_valids got %b want 000", {int_wb_v_o, float_wb_v_o, icache_v_o}); end
    checks++; if ({outstanding_full_o, outstanding_count_o} !== 6'd0) begin errors++; $display("FAIL arst_count got full=%b count=%0d want 0/0", outstanding_full_o, outstanding_count_o); end
    checks++; if (int_wb_data_o !== 32'd0) begin errors++; $display("FAIL arst_data got %h want 0", int_wb_data_o); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if ({int_wb_v_o, float_wb_v_o, icache_v_o} !== 3'b000) begin errors++; $display("FAIL arst_stale got %b want 000", {int_wb_v_o, float_wb_v_o, icache_v_o}); end
    checks++; if (outstanding_count_o !== 5'd0) begin errors++; $display("FAIL arst_count_after got %0d want 0", outstanding_count_o); end
  endtask

`ifdef REMOTE_LOAD_RETURN_PROFILE_EN
  task automatic test_profile();
    issue_n(5);
    @(negedge clk_i);
    returned_v_i = 1'b1; returned_data_i = 32'h00000001; returned_reg_id_i = 5'd1;
    returned_load_info_i = li(0, 0, 0, 0, 0, 2'd0);
    @(negedge clk_i);
    returned_v_i = 1'b0;
    repeat (3) @(negedge clk_i);
    int_wb_yumi_i = 1'b1;
    @(negedge clk_i);
    int_wb_yumi_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      returned_v_i = 1'b1; returned_data_i = 32'h100 + k;
      returned_load_info_i = (k == 3) ? li(1, 0, 0, 0, 0, 2'd0) : li(0, 0, 0, 0, 0, 2'd0);
      @(negedge clk_i);
      returned_v_i = 1'b0;
      if (k == 3) float_wb_yumi_i = 1'b1; else int_wb_yumi_i = 1'b1;
      @(negedge clk_i);
      float_wb_yumi_i = 1'b0; int_wb_yumi_i = 1'b0;
    end
    #1;
    checks++; if (prof_int_cnt_o !== 32'd4) begin errors++; $display("FAIL prof_int got %0d want 4", prof_int_cnt_o); end
    checks++; if (prof_float_cnt_o !== 32'd1) begin errors++; $display("FAIL prof_float got %0d want 1", prof_float_cnt_o); end
    checks++; if (prof_icache_cnt_o !== 32'd0) begin errors++; $display("FAIL prof_icache got %0d want 0", prof_icache_cnt_o); end
    checks++; if (prof_stall_cycles_o !== 32'd3) begin errors++; $display("FAIL prof_stall got %0d want 3", prof_stall_cycles_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_byte_signed();
    test_half();
    test_routing();
    test_credits();
    test_async_reset();
`ifdef REMOTE_LOAD_RETURN_PROFILE_EN
    test_profile();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
